// File: rtl/sn74hc4017_pkg.sv
// Shared constants for the SN74HC4017 decade counter: Johnson codes, pin map
// and decode helpers used by the counter core and the top-level pin wrapper.
package sn74hc4017_pkg;

  typedef logic [4:0] jcode_t;

  typedef struct packed {
    logic       co;
    logic [9:0] q;
  } decode_t;

  localparam jcode_t JC0 = 5'b00000;
  localparam jcode_t JC1 = 5'b00001;
  localparam jcode_t JC2 = 5'b00011;
  localparam jcode_t JC3 = 5'b00111;
  localparam jcode_t JC4 = 5'b01111;
  localparam jcode_t JC5 = 5'b11111;
  localparam jcode_t JC6 = 5'b11110;
  localparam jcode_t JC7 = 5'b11100;
  localparam jcode_t JC8 = 5'b11000;
  localparam jcode_t JC9 = 5'b10000;

  localparam jcode_t JC_TABLE [10] = '{JC0, JC1, JC2, JC3, JC4, JC5, JC6, JC7, JC8, JC9};

  // Package pin carrying Qn, indexed by count n.
  localparam int Q_PIN [10] = '{3, 2, 4, 7, 10, 1, 5, 6, 9, 11};

  localparam logic [3:0] CO_LIMIT      = 4'd5;
  localparam logic [3:0] COUNT_ILLEGAL = 4'hF;

  function automatic logic [3:0] code_to_count(input jcode_t j);
    logic [3:0] c;
    c = COUNT_ILLEGAL;
    for (int n = 0; n < 10; n++) begin
      if (j == JC_TABLE[n]) c = 4'(n);
    end
    return c;
  endfunction

  function automatic int pin_to_q(input int pin);
    int idx;
    idx = 0;
    for (int n = 0; n < 10; n++) begin
      if (Q_PIN[n] == pin) idx = n;
    end
    return idx;
  endfunction

endpackage

// File: rtl/sn74hc4017_if.sv
// Package-pin bundle of the SN74HC4017 except CLK (P14) and RESET (P15),
// which stay as plain ports on the device.
interface sn74hc4017_if;

  logic p13;
  logic p16;
  logic p8;

  logic p1;
  logic p2;
  logic p3;
  logic p4;
  logic p5;
  logic p6;
  logic p7;
  logic p9;
  logic p10;
  logic p11;
  logic p12;

  modport master (
    input  p13, p16, p8,
    output p1, p2, p3, p4, p5, p6, p7, p9, p10, p11, p12
  );

  modport slave (
    output p13, p16, p8,
    input  p1, p2, p3, p4, p5, p6, p7, p9, p10, p11, p12
  );

endinterface

// File: rtl/sn74hc4017_johnson5.sv
// Five-stage Johnson register with async reset, count enable and recovery
// from any of the 22 codes outside the decade sequence.
module sn74hc4017_johnson5
  import sn74hc4017_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  output jcode_t j
);

  // Illegal codes collapse straight to count 0 rather than walking the ring.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      j <= JC0;
    end else if (en) begin
      if (code_to_count(j) == COUNT_ILLEGAL) begin
        j <= JC0;
      end else begin
        j <= {j[3:0], ~j[4]};
      end
    end
  end

endmodule

// File: rtl/sn74hc4017.sv
// SN74HC4017 decade counter/divider: power gating, one-hot decode, carry-out
// and mapping of the decoded outputs onto the 16-pin DIP.
module sn74hc4017
  import sn74hc4017_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  sn74hc4017_if.master pins
);

  logic       powered;
  logic       core_rst;
  logic       core_en;
  jcode_t     j;
  logic [3:0] count;
  decode_t    dec;

  // Unpowered, the part ignores every input and simply keeps its state.
  assign powered  = pins.p16 & ~pins.p8;
  assign core_rst = rst & powered;
  assign core_en  = powered & ~pins.p13;

  sn74hc4017_johnson5 u_johnson5 (
    .clk (clk),
    .rst (core_rst),
    .en  (core_en),
    .j   (j)
  );

  assign count = code_to_count(j);

  always_comb begin
    dec = '0;
    for (int n = 0; n < 10; n++) begin
      dec.q[n] = (j == JC_TABLE[n]);
    end
    dec.co = (count != COUNT_ILLEGAL) && (count < CO_LIMIT);
  end

  localparam int IDX_P1  = pin_to_q(1);
  localparam int IDX_P2  = pin_to_q(2);
  localparam int IDX_P3  = pin_to_q(3);
  localparam int IDX_P4  = pin_to_q(4);
  localparam int IDX_P5  = pin_to_q(5);
  localparam int IDX_P6  = pin_to_q(6);
  localparam int IDX_P7  = pin_to_q(7);
  localparam int IDX_P9  = pin_to_q(9);
  localparam int IDX_P10 = pin_to_q(10);
  localparam int IDX_P11 = pin_to_q(11);

  assign pins.p1  = dec.q[IDX_P1];
  assign pins.p2  = dec.q[IDX_P2];
  assign pins.p3  = dec.q[IDX_P3];
  assign pins.p4  = dec.q[IDX_P4];
  assign pins.p5  = dec.q[IDX_P5];
  assign pins.p6  = dec.q[IDX_P6];
  assign pins.p7  = dec.q[IDX_P7];
  assign pins.p9  = dec.q[IDX_P9];
  assign pins.p10 = dec.q[IDX_P10];
  assign pins.p11 = dec.q[IDX_P11];
  assign pins.p12 = dec.co;

endmodule

// File: tb/tb_sn74hc4017.sv
// Self-checking bench for sn74hc4017: directed scenarios followed by random
// power/reset/inhibit traffic, all compared against an integer decade model.
module tb_sn74hc4017;

  logic clk;
  logic rst;

  sn74hc4017_if bus ();

  sn74hc4017 dut (
    .clk  (clk),
    .rst  (rst),
    .pins (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run;
  int tests_failed;
  int m_count;
  bit m_known;
  bit m_illegal;

  // Pin order follows the datasheet: {CO, Q9..Q0}.
  function automatic logic [10:0] observed();
    return {bus.p12, bus.p11, bus.p9, bus.p6, bus.p5, bus.p1,
            bus.p10, bus.p7, bus.p4, bus.p2, bus.p3};
  endfunction

  function automatic logic [10:0] expected();
    logic [10:0] e;
    e = '0;
    if (!m_illegal) begin
      e[m_count] = 1'b1;
      e[10]      = (m_count < 5);
    end
    return e;
  endfunction

  function automatic bit powered();
    return bus.p16 && !bus.p8;
  endfunction

  task automatic checkOutput(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %b, expected %b (model count %0d)", tag, obs, exp, m_count);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit inh, input bit vcc, input bit gnd);
    @(negedge clk);
    rst     = r;
    bus.p13 = inh;
    bus.p16 = vcc;
    bus.p8  = gnd;
    if (powered() && r) begin
      m_count   = 0;
      m_known   = 1'b1;
      m_illegal = 1'b0;
    end
    #1;
    if (m_known) checkOutput("async", observed(), expected());
  endtask

  task automatic clockEdges(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (powered() && !rst && !bus.p13 && m_known) begin
        if (m_illegal) begin
          m_count   = 0;
          m_illegal = 1'b0;
        end else begin
          m_count = (m_count + 1) % 10;
        end
      end
      #1;
      if (m_known) checkOutput(tag, observed(), expected());
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    m_count      = 0;
    m_known      = 1'b0;
    m_illegal    = 1'b0;
    rst          = 1'b0;
    bus.p13      = 1'b0;
    bus.p16      = 1'b1;
    bus.p8       = 1'b0;

    applyStimulus(1, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    clockEdges(12, "count_seq");

    clockEdges(1, "to_3");
    applyStimulus(0, 1, 1, 0);
    clockEdges(4, "inhibit_hold");
    applyStimulus(0, 0, 1, 0);
    clockEdges(1, "inhibit_release");

    clockEdges(3, "to_7");
    applyStimulus(1, 0, 1, 0);
    clockEdges(3, "reset_hold");
    applyStimulus(0, 0, 1, 0);
    clockEdges(1, "reset_release");

    clockEdges(1, "to_2");
    applyStimulus(0, 0, 0, 0);
    clockEdges(3, "unpowered_clk");
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    clockEdges(1, "repowered");

    // Park at count 9 so the recovery edge lands on 0 regardless of force release semantics.
    clockEdges(6, "to_9");
    @(negedge clk);
    force dut.u_johnson5.j = 5'b01010;
    m_illegal = 1'b1;
    #1;
    checkOutput("illegal_decode", observed(), expected());
    release dut.u_johnson5.j;
    clockEdges(1, "illegal_recover");

    for (int k = 0; k < 400; k++) begin
      applyStimulus($urandom_range(0, 19) == 0,
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 9) != 0,
                    $urandom_range(0, 19) == 0);
      clockEdges(1, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sn74hc4017.md
Name: sn74hc4017

Overview:
Pin-accurate behavioural model of the SN74HC4017 decade counter/divider with 10 one-hot decoded outputs, in a 16-pin DIP. It is the sequencing source upstream of the sn7486 quad-XOR stage on the lab boards. Decoded outputs and carry-out drive the XOR inputs for parity and phase-compare exercises. The core is a 5-stage Johnson counter with a one-hot decoder and power-pin gating.

Parameters:
none. Fixed-function part; pin map and count modulus are fixed at 10.

Ports:
P14  input   1  CLK; counter advances on the rising edge
P15  input   1  RESET; asynchronous, active-high
P13  input   1  CLOCK INHIBIT; active-high, blocks counting
P16  input   1  VCC; must be 1 for the part to operate
P8   input   1  GND; must be 0 for the part to operate
P3   output  1  Q0
P2   output  1  Q1
P4   output  1  Q2
P7   output  1  Q3
P10  output  1  Q4
P1   output  1  Q5
P5   output  1  Q6
P6   output  1  Q7
P9   output  1  Q8
P11  output  1  Q9
P12  output  1  CO (carry-out)

Behaviour:
Interface (already decided):
- One clock, P14.
- Reset is P15: asynchronous, active-high.

Powered condition:
- Powered means P16==1 and P8==0.
- While unpowered: clock, inhibit and reset are all ignored; internal state and every output hold their last value.
- Before the first powered reset, state is X.

Reset:
- Applies while powered and P15==1, immediately (asynchronous).
- Johnson state J[4:0]=00000, giving count 0.
- Outputs after reset: Q0 (P3)=1, Q1..Q9=0, CO (P12)=1.
- While P15 stays high, all P14 edges are ignored.

Counting:
- The counter advances on a P14 rising edge when powered, P15==0 and P13==0.
- If P13==1 at the edge, the state holds.
- A falling edge of P13 never advances the count. This is a documented deviation from the silicon.

Johnson sequence (J[4:0], count 0..9):
- 00000, 00001, 00011, 00111, 01111, 11111, 11110, 11100, 11000, 10000.
- Next-state rule: J <= {J[3:0], ~J[4]}.
- Count 9 wraps to count 0 on the next enabled edge.

Illegal states:
- Any of the 22 non-sequence codes (reachable only by X or forced state) loads 00000 on the next enabled edge.
- While in an illegal code, all Q outputs are 0 and CO=0.

Decode:
- Qn=1 iff count==n. Exactly one Q is high in any legal state.
- CO=1 for counts 0–4 and 0 for counts 5–9.
- CO rises on the 9→0 transition, giving a divide-by-10 output with 50% duty cycle.

Latency:
- Outputs update in the same timestep as the clock edge or reset assertion (zero-delay model).

Simultaneous events:
- Reset deasserting in the same timestep as a P14 rise: the edge is ignored and the count stays 0.
- P13 changing in the same timestep as a P14 rise: the pre-edge value of P13 is used.

Reset mid-operation:
- Asserting reset at any count forces count 0 in the same timestep.
- The first count after release needs a fresh P14 rising edge.

Decomposition:
- Shared package sn74hc4017_pkg holds:
  - the 10 legal Johnson-code constants (JC0..JC9);
  - a count-to-pin mapping constant for Q0..Q9 (P3,P2,P4,P7,P10,P1,P5,P6,P9,P11);
  - CO threshold constant (count<5).
- Sub-module johnson5: 5-bit Johnson register with async active-high reset, enable and illegal-state recovery, outputting J[4:0].
- The top level handles power gating, the one-hot decode and the pin mapping.

Test Plan:
- Power up (P16=1, P8=0), pulse P15 high → P3=1, all other Q=0, P12=1.
- Release reset, apply 12 P14 rising edges with P13=0 → Q sequence P2,P4,P7,P10,P1,P5,P6,P9,P11,P3,P2,P4. P12 falls at edge 5 and rises at edge 10.
- Advance to count 3, set P13=1, apply 4 edges → P7 stays 1. Set P13=0, 1 edge → P10=1.
- Advance to count 7 (P6=1), assert P15 between edges → P3=1 and P12=1 immediately. Edges during reset produce no change. Release plus 1 edge → P2=1.
- At count 2, set P16=0, apply 3 edges and a reset pulse → P4 stays 1. Restore P16=1, 1 edge → P7=1.
- Force johnson5 state to 01010 → all Q=0, P12=0. Next edge → state 00000, P3=1, P12=1.
